// File: rtl/gshare_branch_predictor.sv
// -----------------------------------------------------------------------------
// gshare_branch_predictor
//
// Fetch-stage next-PC predictor. A global branch history register (BHR) is
// XORed with the PC word index to select a 2-bit saturating counter (BHT). A
// direct-mapped branch target buffer (BTB) supplies the taken target. Lookup
// is purely combinational. Training arrives from EX with the BHR value that
// was used at prediction time, so the counter that made the prediction is the
// one that gets trained.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           asynchronous active-low reset
//   current_pc      fetch PC
//   pred_next_pc    predicted next fetch PC
//   pred_taken      BTB hit and counter MSB set
//   pred_bhr        BHR value used for this prediction (carried to EX)
//   update_valid    EX resolves an instruction this cycle
//   is_control_inst resolved instruction is a branch/jump
//   update_pc       PC of the resolved instruction
//   update_bhr      pred_bhr that travelled with that instruction
//   actual_taken    resolved direction
//   actual_target   resolved target
// -----------------------------------------------------------------------------
module gshare_branch_predictor #(
   parameter int INDEX_BITS = 5,
   parameter int PC_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PC_WIDTH-1:0]   current_pc,
   output logic [PC_WIDTH-1:0]   pred_next_pc,
   output logic                  pred_taken,
   output logic [INDEX_BITS-1:0] pred_bhr,
   input  logic                  update_valid,
   input  logic                  is_control_inst,
   input  logic [PC_WIDTH-1:0]   update_pc,
   input  logic [INDEX_BITS-1:0] update_bhr,
   input  logic                  actual_taken,
   input  logic [PC_WIDTH-1:0]   actual_target
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

   // Read views of the per-entry storage held in the generate blocks below.
   logic [1:0]          bht_ctr   [ENTRIES];
   logic                btb_valid [ENTRIES];
   logic [TAG_W-1:0]    btb_tag   [ENTRIES];
   logic [PC_WIDTH-1:0] btb_tgt   [ENTRIES];

   logic [INDEX_BITS-1:0] bhr_q, bhr_d;

   // ---------------------------------------------------------------- lookup
   logic [INDEX_BITS-1:0] lk_btb_idx, lk_bht_idx;
   logic [TAG_W-1:0]      lk_tag;
   logic                  lk_hit;

   assign lk_btb_idx = current_pc[INDEX_BITS+1:2];
   assign lk_tag     = current_pc[PC_WIDTH-1:INDEX_BITS+2];
   assign lk_bht_idx = lk_btb_idx ^ bhr_q;
   assign lk_hit     = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);

   assign pred_taken   = lk_hit && bht_ctr[lk_bht_idx][1];
   assign pred_next_pc = pred_taken ? btb_tgt[lk_btb_idx] : current_pc + PC_WIDTH'(4);
   assign pred_bhr     = bhr_q;

   // ---------------------------------------------------------------- update
   logic                  upd_en;
   logic                  upd_btb_wr;
   logic [INDEX_BITS-1:0] upd_btb_idx, upd_bht_idx;
   logic [TAG_W-1:0]      upd_tag;
   logic [1:0]            upd_ctr, ctr_d;

   assign upd_en      = update_valid && is_control_inst;
   assign upd_btb_wr  = upd_en && actual_taken;
   assign upd_btb_idx = update_pc[INDEX_BITS+1:2];
   assign upd_tag     = update_pc[PC_WIDTH-1:INDEX_BITS+2];
   // Index with the history the prediction used, not the current BHR.
   assign upd_bht_idx = upd_btb_idx ^ update_bhr;
   assign upd_ctr     = bht_ctr[upd_bht_idx];

   always_comb begin
      ctr_d = upd_ctr;
      if (actual_taken) begin
         if (upd_ctr != 2'b11) ctr_d = upd_ctr + 2'd1;
      end else begin
         if (upd_ctr != 2'b00) ctr_d = upd_ctr - 2'd1;
      end
   end

   // History is non-speculative: it only shifts on resolved control flow.
   assign bhr_d = {bhr_q[INDEX_BITS-2:0], actual_taken};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bhr_q <= '0;
      end else if (upd_en) begin
         bhr_q <= bhr_d;
      end
   end

   // ---------------------------------------------------------------- storage
   for (genvar gi = 0; gi < ENTRIES; gi++) begin : gen_entry
      logic [1:0]          ctr_q;
      logic                valid_q;
      logic [TAG_W-1:0]    tag_q;
      logic [PC_WIDTH-1:0] tgt_q;
      logic                bht_sel, btb_sel;

      assign bht_sel = upd_en     && (upd_bht_idx == INDEX_BITS'(gi));
      assign btb_sel = upd_btb_wr && (upd_btb_idx == INDEX_BITS'(gi));

      // Counters start weakly not-taken; valid bits clear on reset.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            ctr_q   <= 2'b01;
            valid_q <= 1'b0;
         end else begin
            if (bht_sel) ctr_q   <= ctr_d;
            if (btb_sel) valid_q <= 1'b1;
         end
      end

      // Tag and target are qualified by valid, so they need no reset.
      always_ff @(posedge clk) begin
         if (btb_sel) begin
            tag_q <= upd_tag;
            tgt_q <= actual_target;
         end
      end

      assign bht_ctr[gi]   = ctr_q;
      assign btb_valid[gi] = valid_q;
      assign btb_tag[gi]   = tag_q;
      assign btb_tgt[gi]   = tgt_q;
   end

   // Byte-offset bits of the PCs do not participate in indexing.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{current_pc[1:0], update_pc[1:0]};

endmodule
